// File: rtl/csa_sum_accumulator.sv
// csa_sum_accumulator: first clocked stage after the carry-save adder.
// Collects a group of (N+1)-bit sums into an ACC_W-bit accumulator and
// presents the group total on a valid/ready output handshake.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      input beat handshake (in_ready is registered)
//   in_sum, in_carry         adder sum and carry-out (carry=1 flags an error)
//   in_last                  closes the group on this beat
//   out_valid / out_ready    result handshake
//   out_acc                  group total modulo 2^ACC_W
//   out_count                beats in the group
//   out_ovf, out_err         sticky wrap / carry-error flags for the group
module csa_sum_accumulator #(
  parameter int unsigned N       = 32,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned MAX_CNT = 16,
  localparam int unsigned CNT_W  = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  input  logic             in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [SUM_W-1:0]   sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  // in_ready is a register, so acceptance never depends on out_ready
  assign accept = in_valid & in_ready;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    // Extra top bit captures the carry-out of the ACC_W-bit add
    sum_ext = {1'b0, acc_q} + SUM_W'(in_sum);
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(in_sum);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          err_d   = in_carry;
          state_d = (in_last || (MAX_CNT == 1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = sum_ext[ACC_W-1:0];
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | sum_ext[ACC_W];
          err_d   = err_q | in_carry;
          state_d = (in_last || (cnt_inc == CNT_W'(MAX_CNT))) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and decoded handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      in_ready  <= (state_d != DONE);
      out_valid <= (state_d == DONE);
    end
  end

  // Result fields hold until the next group's first beat reloads them
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

endmodule
